// File: rtl/fpga_serial_adder_pkg.sv
// rtl/fpga_serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package fpga_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fpga_carry_logic.sv
// rtl/fpga_carry_logic.sv - single-bit full-adder carry cell (majority of a, b, carry in)
module fpga_carry_logic (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_in_i,
    output logic carry_out_o
);

    assign carry_out_o = (a_i & b_i) | (a_i & carry_in_i) | (b_i & carry_in_i);

endmodule

// File: rtl/fpga_serial_adder.sv
// rtl/fpga_serial_adder.sv - bit-serial LSB-first adder; FPGA_SERIAL_ADDER_SUB_EN adds sub_i for A-B
module fpga_serial_adder
    import fpga_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef FPGA_SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sub_req, b_bit, sum_bit, cell_cout;

`ifdef FPGA_SERIAL_ADDER_SUB_EN
    assign sub_req = sub_i;
`else
    assign sub_req = 1'b0;
`endif

    // Subtraction is A + ~B + 1: B inverted at the cell input, carry seeded with 1.
    assign b_bit   = b_q[0] ^ sub_q;
    assign sum_bit = a_q[0] ^ b_bit ^ carry_q;

    fpga_carry_logic u_carry (
        .a_i         (a_q[0]),
        .b_i         (b_bit),
        .carry_in_i  (carry_q),
        .carry_out_o (cell_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_req;
                    carry_d = sub_req;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = (res_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
                carry_d = cell_cout;
                cnt_d   = cnt_q + 1'b1;
                // Outputs load on the edge into DONE so they are valid alongside done_o.
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_d;
                    cout_d  = cell_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign sum_o   = sum_q;
    assign carry_o = cout_q;

endmodule

// File: tb/tb_fpga_serial_adder.sv
// tb/tb_fpga_serial_adder.sv - checks WIDTH=8 and WIDTH=1 adders against an arithmetic model
module tb_fpga_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st[2];
    logic [31:0] av[2], bv[2];
    logic        sb[2];

    logic        busy8, done8, cy8, busy1, done1, cy1;
    logic [7:0]  sum8;
    logic [0:0]  sum1;
    logic        busy[2], done[2], cy[2];
    logic [31:0] sm[2];

    assign busy[0] = busy8;
    assign busy[1] = busy1;
    assign done[0] = done8;
    assign done[1] = done1;
    assign cy[0]   = cy8;
    assign cy[1]   = cy1;
    assign sm[0]   = {24'd0, sum8};
    assign sm[1]   = {31'd0, sum1};

    fpga_serial_adder #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (st[0]),
        .a_i     (av[0][7:0]),
        .b_i     (bv[0][7:0]),
`ifdef FPGA_SERIAL_ADDER_SUB_EN
        .sub_i   (sb[0]),
`endif
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .carry_o (cy8)
    );

    fpga_serial_adder #(.WIDTH(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (st[1]),
        .a_i     (av[1][0:0]),
        .b_i     (bv[1][0:0]),
`ifdef FPGA_SERIAL_ADDER_SUB_EN
        .sub_i   (sb[1]),
`endif
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .carry_o (cy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Model: an accepted start makes the block busy for W+1 cycles, the last one
    // being the done cycle, whose result is plain integer A+B or A+~B+1.
    int          wd[2];
    int          m_cyc[2];
    logic [31:0] m_a[2], m_b[2], m_sum[2];
    logic        m_sub[2], m_cy[2];
    bit          m_valid = 1'b0;

    function automatic logic [32:0] model_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic [63:0] mask, full;
        mask = (64'd1 << w) - 64'd1;
        full = ({32'd0, a} & mask) + (s ? ((~{32'd0, b}) & mask) + 64'd1 : ({32'd0, b} & mask));
        return {full[w], 32'(full & mask)};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cyc[i] <= 0;
                m_sum[i] <= '0;
                m_cy[i]  <= 1'b0;
            end else if (m_cyc[i] == 0) begin
                if (st[i]) begin
                    m_a[i]   <= av[i];
                    m_b[i]   <= bv[i];
`ifdef FPGA_SERIAL_ADDER_SUB_EN
                    m_sub[i] <= sb[i];
`else
                    m_sub[i] <= 1'b0;
`endif
                    m_cyc[i] <= wd[i] + 1;
                end
            end else begin
                if (m_cyc[i] == 2)
                    {m_cy[i], m_sum[i]} <= model_op(wd[i], m_a[i], m_b[i], m_sub[i]);
                m_cyc[i] <= m_cyc[i] - 1;
            end
        end
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i),  {31'd0, busy[i]}, {31'd0, m_cyc[i] != 0});
                chk($sformatf("done%0d", i),  {31'd0, done[i]}, {31'd0, m_cyc[i] == 1});
                chk($sformatf("sum%0d", i),   sm[i], m_sum[i]);
                chk($sformatf("carry%0d", i), {31'd0, cy[i]}, {31'd0, m_cy[i]});
            end
        end
    end

    // Drives one operation; optional start injection and reset at a given cycle after start.
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int inj, input int rst_at,
                          output int lat, output int nbusy, output int ndone);
        @(negedge clk);
        st[i] = 1'b1; av[i] = a; bv[i] = b; sb[i] = s;
        @(negedge clk);
        st[i] = 1'b0;
        lat = 0; nbusy = 0; ndone = 0;
        for (int n = 1; n <= 14; n++) begin
            if (busy[i]) nbusy++;
            if (done[i]) begin
                ndone++;
                if (lat == 0) lat = n;
            end
            if (inj != 0 && n == inj) begin
                st[i] = 1'b1; av[i] = ~a; bv[i] = ~b; sb[i] = ~s;
            end
            if (inj != 0 && n == inj + 1) st[i] = 1'b0;
            if (rst_at != 0 && n == rst_at) rst = 1'b1;
            if (rst_at != 0 && n == rst_at + 1) begin
                rst = 1'b0;
                chk("abort_busy",  {31'd0, busy[i]}, 32'd0);
                chk("abort_done",  {31'd0, done[i]}, 32'd0);
                chk("abort_sum",   sm[i], 32'd0);
                chk("abort_carry", {31'd0, cy[i]}, 32'd0);
            end
            @(negedge clk);
        end
    endtask

    int lat, nb, nd;

    initial begin
        wd[0] = 8; wd[1] = 1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; av[i] = '0; bv[i] = '0; sb[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_sum",  sm[0], 32'd0);
        chk("rst_carry", {31'd0, cy8}, 32'd0);
        rst = 1'b0;

        run_op(0, 32'h5A, 32'h3C, 1'b0, 0, 0, lat, nb, nd);
        chk("add5a3c_sum", sm[0], 32'h96);
        chk("add5a3c_carry", {31'd0, cy8}, 32'd0);
        chk("add5a3c_latency", lat, 9);

        run_op(0, 32'hFF, 32'h01, 1'b0, 0, 0, lat, nb, nd);
        chk("addff01_sum", sm[0], 32'h00);
        chk("addff01_carry", {31'd0, cy8}, 32'd1);
        chk("addff01_busy_cycles", nb, 9);

        run_op(0, 32'h80, 32'h80, 1'b0, 0, 0, lat, nb, nd);
        chk("add8080_sum", sm[0], 32'h00);
        chk("add8080_carry", {31'd0, cy8}, 32'd1);

        run_op(0, 32'h12, 32'h34, 1'b0, 3, 0, lat, nb, nd);
        chk("ignore_start_sum", sm[0], 32'h46);
        chk("ignore_start_done_pulses", nd, 1);

        run_op(0, 32'h77, 32'h11, 1'b0, 0, 4, lat, nb, nd);
        chk("abort_no_done", nd, 0);
        run_op(0, 32'h20, 32'h22, 1'b0, 0, 0, lat, nb, nd);
        chk("after_abort_sum", sm[0], 32'h42);
        chk("after_abort_latency", lat, 9);

`ifdef FPGA_SERIAL_ADDER_SUB_EN
        run_op(0, 32'h10, 32'h01, 1'b1, 0, 0, lat, nb, nd);
        chk("sub1001_sum", sm[0], 32'h0F);
        chk("sub1001_carry", {31'd0, cy8}, 32'd1);
        run_op(0, 32'h01, 32'h02, 1'b1, 0, 0, lat, nb, nd);
        chk("sub0102_sum", sm[0], 32'hFF);
        chk("sub0102_carry", {31'd0, cy8}, 32'd0);
`endif

        for (int s = 0; s < 2; s++) begin
`ifndef FPGA_SERIAL_ADDER_SUB_EN
            if (s == 1) break;
`endif
            for (int a = 0; a < 2; a++) begin
                for (int b = 0; b < 2; b++) begin
                    run_op(1, 32'(a), 32'(b), s[0], 0, 0, lat, nb, nd);
                    chk($sformatf("w1_s%0d_a%0d_b%0d_sum", s, a, b), sm[1], 32'(a ^ b));
                    chk($sformatf("w1_s%0d_a%0d_b%0d_carry", s, a, b), {31'd0, cy1},
                        (s == 1) ? 32'(a | (b ^ 1)) : 32'(a & b));
                    chk($sformatf("w1_s%0d_a%0d_b%0d_latency", s, a, b), lat, 2);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_serial_adder.md
FPGA_SERIAL_ADDER -- requirements
Module: fpga_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 1..32.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a_i  input  WIDTH  operand A; captured in the cycle start_i is accepted.
REQ-006 b_i  input  WIDTH  operand B; captured in the cycle start_i is accepted.
REQ-007 sub_i  input  1  present only with FPGA_SERIAL_ADDER_SUB_EN: 1 = A-B, 0 = A+B; captured with the operands.
REQ-008 busy_o  output  1  high in RUN and DONE.
REQ-009 done_o  output  1  one-cycle pulse; sum_o and carry_o are valid from this cycle.
REQ-010 sum_o  output  WIDTH  result; held from DONE until the next accepted start_i.
REQ-011 carry_o  output  1  final carry out of the MSB; held like sum_o.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start_i=1: load A and B into shift registers, carry flop <= 0 (1 if subtracting), bit counter <= 0, go to RUN.
REQ-014 IDLE with start_i=0: remain in IDLE; sum_o and carry_o hold their values.
REQ-015 Each RUN cycle: present operand bit k (LSB first) and the carry flop to one carry cell.
REQ-016 In that cycle, sum bit k = a^b^c; shift it into the result register MSB-first so bit k lands at index k after WIDTH cycles.
REQ-017 In that cycle, carry flop <= carry cell output; counter += 1.
REQ-018 RUN SHALL last exactly WIDTH cycles, then go to DONE; WIDTH=1 gives one RUN cycle.
REQ-019 DONE: assert done_o for one cycle, update carry_o from the carry flop, go to IDLE unconditionally.
REQ-020 Latency: start_i accepted at edge N gives done_o high in cycle N+WIDTH+1 (counting edges).
REQ-021 start_i in RUN or DONE SHALL be ignored; captured operands are unaffected.
REQ-022 Back-to-back operation: start_i is accepted in the cycle after done_o.
REQ-023 sum_o and carry_o SHALL change only on entry to DONE, never during RUN.
REQ-024 Counter width SHALL be $clog2(WIDTH+1); counter wrap-around SHALL be unreachable.

Reset
REQ-025 rst_i=1 SHALL force IDLE and zero: busy_o, done_o, sum_o, carry_o, shift registers, carry flop and counter.
REQ-026 Reset in RUN or DONE SHALL abort the operation; no done_o pulse is produced for it.
REQ-027 Reset SHALL take priority over start_i in the same cycle.

Configuration
REQ-028 Macro FPGA_SERIAL_ADDER_SUB_EN defined: sub_i port exists.
REQ-029 With subtraction selected, B is inverted bitwise as it enters the carry cell and the carry flop is initialised to 1.
REQ-030 With subtraction selected, carry_o=1 means no borrow.
REQ-031 Macro undefined: no sub_i port; the block is add-only with carry init 0.

Structure
REQ-032 Package fpga_serial_adder_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constant for the default WIDTH.
REQ-033 The carry SHALL be computed by one instance of the existing fpga_carry_logic cell.
REQ-034 Its carry_in_i is driven by the carry flop and its carry_out_o feeds the carry flop's D input.
REQ-035 No other sub-module SHALL be used.

Verification
REQ-036 WIDTH=8, A=0x5A, B=0x3C add -> done_o at cycle 9 after start, sum_o=0x96, carry_o=0.
REQ-037 A=0xFF, B=0x01 add -> sum_o=0x00, carry_o=1; busy_o high for 9 cycles.
REQ-038 start_i pulsed with new operands during RUN -> ignored; first result is unchanged, with exactly one done_o pulse.
REQ-039 rst_i asserted at RUN cycle 4 -> next cycle IDLE, all outputs 0, no done_o; a later start gives a correct result.
REQ-040 With SUB_EN: A=0x10, B=0x01 sub -> sum_o=0x0F, carry_o=1.
REQ-041 With SUB_EN: A=0x01, B=0x02 sub -> sum_o=0xFF, carry_o=0.
REQ-042 WIDTH=1 sweep of all 4 a/b combinations (plus sub_i when SUB_EN) -> result matches the truth table; done_o two cycles after start.
